// File: rtl/dvt_init_pkg.sv
// rtl/dvt_init_pkg.sv - shared types for the DVT-flag initiator
// Purpose: FSM state, completion status, and queued request record used by
//          dvt_flag_initiator and dvt_req_fifo.
package dvt_init_pkg;

  // Queue entries carry the widest supported fields; the top zero-extends
  // req_bit/req_pat on the way in and truncates back on the way out.
  localparam int DVTF_PAT_W = 32;
  localparam int DVTF_BIT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RAISE = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_BADBIT  = 2'd2
  } status_e;

  typedef struct packed {
    logic [DVTF_BIT_W-1:0] bit_idx;
    logic [DVTF_PAT_W-1:0] pat;
  } req_t;

endpackage

// File: rtl/dvt_req_fifo.sv
// rtl/dvt_req_fifo.sv - synchronous request queue of req_t
// Purpose: power-of-2 deep FIFO; head entry is read straight from the
//          registered storage so it is valid whenever o_empty is low.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_push, i_data    write strobe and entry (ignored when full unless popping)
//   i_pop, o_head     read strobe and current head entry
//   o_full, o_empty   occupancy flags
//   o_count           number of stored entries
module dvt_req_fifo
  import dvt_init_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  req_t                     i_data,
  input  logic                     i_pop,
  output req_t                     o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  req_t           r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a full queue may push and pop together.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dvt_flag_initiator.sv
// rtl/dvt_flag_initiator.sv - initiator side of the DVT-flag command handshake
// Purpose: queues flag requests, raises one dvtFlags bit at a time with its
//          pattern, waits for the responder to self-clear, reports status.
// Optional feature: define DVT_FLAG_INIT_TIMEOUT_EN to abandon a raised flag
//          after TIMEOUT cycles without a clear (status TIMEOUT).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_bit, req_pat                flag index and pattern to present
//   dvt_flag_o, dvt_pat_o           one-hot flag and pattern toward responder
//   dvt_clr_i, dvt_pat_i            responder self-clear level and readback
//   resp_valid/resp_status/resp_pat one-cycle completion report
//   busy                            work in flight or queued
module dvt_flag_initiator
  import dvt_init_pkg::*;
#(
  parameter  int FLAG_W     = 32,
  parameter  int PAT_W      = 32,
  parameter  int FIFO_DEPTH = 4,
  parameter  int TIMEOUT    = 4096,
  localparam int BIT_W      = (FLAG_W > 1) ? $clog2(FLAG_W) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [BIT_W-1:0]   req_bit,
  input  logic [PAT_W-1:0]   req_pat,
  output logic [FLAG_W-1:0]  dvt_flag_o,
  output logic [PAT_W-1:0]   dvt_pat_o,
  input  logic [FLAG_W-1:0]  dvt_clr_i,
  input  logic [PAT_W-1:0]   dvt_pat_i,
  output logic               resp_valid,
  output logic [1:0]         resp_status,
  output logic [PAT_W-1:0]   resp_pat,
  output logic               busy
);

  state_e                    r_state;
  logic [FLAG_W-1:0]         r_flag;
  logic [PAT_W-1:0]          r_pat_o;
  logic                      r_resp_valid;
  status_e                   r_status;
  logic [PAT_W-1:0]          r_resp_pat;
  logic [BIT_W-1:0]          r_bit;
  logic                      r_bad;

  req_t                      w_push_data;
  req_t                      w_head;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;

`ifdef DVT_FLAG_INIT_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0]          r_tmo_cnt;
`endif

  assign w_push_data = {DVTF_BIT_W'(req_bit), DVTF_PAT_W'(req_pat)};
  assign w_push      = req_valid && !w_full;
  assign w_pop       = (r_state == IDLE) && !w_empty;

  dvt_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign req_ready   = !w_full;
  assign busy        = (r_state != IDLE) || (w_count != '0);
  assign dvt_flag_o  = r_flag;
  assign dvt_pat_o   = r_pat_o;
  assign resp_valid  = r_resp_valid;
  assign resp_status = r_status;
  assign resp_pat    = r_resp_pat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_flag       <= '0;
      r_pat_o      <= '0;
      r_resp_valid <= 1'b0;
      r_status     <= ST_OK;
      r_resp_pat   <= '0;
      r_bit        <= '0;
      r_bad        <= 1'b0;
`ifdef DVT_FLAG_INIT_TIMEOUT_EN
      r_tmo_cnt    <= '0;
`endif
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // Pattern is loaded on the pop so it is already stable for the
          // whole SETUP cycle, ahead of the flag edge.
          if (!w_empty) begin
            r_bit   <= BIT_W'(w_head.bit_idx);
            r_bad   <= (int'(w_head.bit_idx) >= FLAG_W);
            r_pat_o <= PAT_W'(w_head.pat);
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (r_bad) begin
            r_resp_valid <= 1'b1;
            r_status     <= ST_BADBIT;
            r_resp_pat   <= '0;
            r_state      <= RESP;
          end else begin
            r_flag  <= FLAG_W'(1) << r_bit;
            r_state <= RAISE;
`ifdef DVT_FLAG_INIT_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end
        end
        RAISE: begin
          // Only the active bit's clear matters; other clear bits are ignored.
          if (dvt_clr_i[r_bit]) begin
            r_flag       <= '0;
            r_resp_valid <= 1'b1;
            r_status     <= ST_OK;
            r_resp_pat   <= dvt_pat_i;
            r_state      <= RESP;
          end
`ifdef DVT_FLAG_INIT_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            r_flag       <= '0;
            r_resp_valid <= 1'b1;
            r_status     <= ST_TIMEOUT;
            r_resp_pat   <= '0;
            r_state      <= RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          // Passing back through IDLE and SETUP keeps the flag low for at
          // least two cycles, so the responder always sees a fresh edge.
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
